// File: rtl/niosv_mem_arb_pkg.sv
// Shared types for the Nios V on-chip memory arbiter: FSM states and requester ids.
package niosv_mem_arb_pkg;

  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int unsigned M0 = 0;
  localparam int unsigned M1 = 1;

endpackage

// File: rtl/niosv_onchip_mem_arbiter_if.sv
// Avalon-MM pipelined requester port: one instance per Nios V master.
interface niosv_onchip_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/niosv_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, pointer flips only on contention.
module niosv_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant[ptr] = 1'b1;
      else              grant      = req;
    end
  end

  // After a contested grant the other side gets priority next time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   ptr <= 1'b0;
    else if (en && req == 2'b11)    ptr <= ~ptr;
  end

endmodule

// File: rtl/niosv_onchip_mem_arbiter.sv
// Shares one single-port RAM (1-cycle read latency) between Nios V instruction and data
// masters with round-robin grant and an optional post-reset zero-fill.
module niosv_onchip_mem_arbiter
  import niosv_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 32,
  parameter bit          SCRUB_ON_RESET = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        reset_req,
  niosv_onchip_mem_arbiter_if.slave   m0,
  niosv_onchip_mem_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W/8-1:0]         mem_byteenable,
  output logic                        mem_chipselect,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_writedata,
  input  logic [DATA_W-1:0]           mem_readdata,
  output logic                        scrub_busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   scrub_cnt, scrub_cnt_nxt;
  logic                rsp_valid, rsp_id;
  logic                issue_read;
  logic [1:0]          req, grant;
  logic                arb_en;

  assign req    = {m1.read | m1.write, m0.read | m0.write};
  assign arb_en = (state == ST_RUN) & ~reset_req;

  niosv_rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .req     (req),
    .grant   (grant)
  );

  // Next state plus RAM port mux: scrub writes own the RAM until the last word is cleared.
  always_comb begin
    state_nxt      = state;
    scrub_cnt_nxt  = scrub_cnt;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    issue_read     = 1'b0;
    unique case (state)
      ST_SCRUB: begin
        mem_chipselect = reset_n;
        mem_write      = reset_n;
        mem_byteenable = '1;
        mem_address    = scrub_cnt;
        scrub_cnt_nxt  = scrub_cnt + ADDR_W'(1);
        if (scrub_cnt == '1) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (grant[M1]) begin
          mem_chipselect = 1'b1;
          mem_write      = m1.write;
          mem_address    = m1.address;
          mem_byteenable = m1.byteenable;
          mem_writedata  = m1.writedata;
          issue_read     = m1.read & ~m1.write;
        end else if (grant[M0]) begin
          mem_chipselect = 1'b1;
          mem_write      = m0.write;
          mem_address    = m0.address;
          mem_byteenable = m0.byteenable;
          mem_writedata  = m0.writedata;
          issue_read     = m0.read & ~m0.write;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCRUB_ON_RESET ? ST_SCRUB : ST_RUN;
      scrub_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      state     <= state_nxt;
      scrub_cnt <= scrub_cnt_nxt;
      rsp_valid <= issue_read;
      rsp_id    <= grant[M1];
    end
  end

  assign scrub_busy = (state == ST_SCRUB);

  // Both requesters see RAM q; only the issuer's strobe qualifies it.
  assign m0.waitrequest   = scrub_busy | reset_req | (req[M0] & ~grant[M0]);
  assign m1.waitrequest   = scrub_busy | reset_req | (req[M1] & ~grant[M1]);
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rsp_valid & (rsp_id == 1'(M0));
  assign m1.readdatavalid = rsp_valid & (rsp_id == 1'(M1));

  logic [BE_W-1:0] be_unused;
  assign be_unused = '0;

endmodule

// File: tb/tb_niosv_onchip_mem_arbiter.sv
// Directed bench for the on-chip memory arbiter with a behavioural byte-enabled RAM.
module tb_niosv_onchip_mem_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          reset_req;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          scrub_busy;

  int errors = 0;
  int checks = 0;

  niosv_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
  niosv_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();

  niosv_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SCRUB_ON_RESET(1'b1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .reset_req      (reset_req),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .scrub_busy     (scrub_busy)
  );

  always #5 clk = ~clk;

  // RAM model: clock enable gated by reset_req, q held otherwise.
  logic [DW-1:0] ram [32];
  logic [DW-1:0] ram_q;
  assign mem_readdata = ram_q;
  always @(posedge clk) begin
    if (!reset_req && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_masters();
    m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.address = '0;
    m0_bus.byteenable = 4'hF; m0_bus.writedata = '0;
    m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.address = '0;
    m1_bus.byteenable = 4'hF; m1_bus.writedata = '0;
  endtask

  initial begin
    int n0, n1, cyc;
    reset_n   = 1'b0;
    reset_req = 1'b0;
    idle_masters();

    // Reset values
    #12;
    chk("rst_scrub_busy", scrub_busy, 1);
    chk("rst_chipselect", mem_chipselect, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_rdv0", m0_bus.readdatavalid, 0);
    chk("rst_rdv1", m1_bus.readdatavalid, 0);
    chk("rst_wait0", m0_bus.waitrequest, 1);

    // Scrub: 32 zero writes, m0 read of address 5 held off until RUN
    tick();
    reset_n = 1'b1;
    m0_bus.read = 1'b1; m0_bus.address = 5'd5;
    settle();
    for (int i = 0; i < 32; i++) begin
      chk("scrub_addr", mem_address, 64'(i));
      chk("scrub_wr", {mem_chipselect, mem_write, mem_byteenable}, 6'h3F);
      chk("scrub_data", mem_writedata, 0);
      chk("scrub_hold0", {scrub_busy, m0_bus.waitrequest}, 2'b11);
      tick(); settle();
    end
    chk("scrub_done", scrub_busy, 0);
    chk("scrub_rd_accept", {m0_bus.waitrequest, mem_chipselect, mem_write}, 3'b010);
    chk("scrub_rd_addr", mem_address, 5);
    tick(); m0_bus.read = 1'b0; settle();
    chk("scrub_rd_rdv", {m0_bus.readdatavalid, m1_bus.readdatavalid}, 2'b10);
    chk("scrub_rd_data", m0_bus.readdata, 0);

    // m1 preload then partial write, m0 reads back
    tick();
    m1_bus.write = 1'b1; m1_bus.address = 5'h10; m1_bus.writedata = 32'h11223344;
    m1_bus.byteenable = 4'hF;
    settle();
    chk("wr_full_accept", {m1_bus.waitrequest, mem_write}, 2'b01);
    tick();
    m1_bus.writedata = 32'hDEADBEEF; m1_bus.byteenable = 4'b0101;
    settle();
    chk("wr_part_be", mem_byteenable, 4'b0101);
    tick();
    m1_bus.write = 1'b0; m0_bus.read = 1'b1; m0_bus.address = 5'h10;
    settle();
    chk("rd_part_accept", m0_bus.waitrequest, 0);
    tick(); m0_bus.read = 1'b0; settle();
    chk("rd_part_rdv", {m0_bus.readdatavalid, m1_bus.readdatavalid}, 2'b10);
    chk("rd_part_data", m0_bus.readdata, 32'h11AD33EF);
    tick(); settle();
    chk("rd_part_one_cycle", m0_bus.readdatavalid, 0);

    // Contention: both read 8 cycles, alternate m0,m1,...
    tick();
    m0_bus.read = 1'b1; m0_bus.address = 5'h10;
    m1_bus.read = 1'b1; m1_bus.address = 5'h11;
    settle();
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      chk("rr_wait", {m0_bus.waitrequest, m1_bus.waitrequest}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        chk("rr_rdv", {m0_bus.readdatavalid, m1_bus.readdatavalid},
            ((k - 1) % 2 == 0) ? 2'b10 : 2'b01);
        if (m0_bus.readdatavalid) begin n0++; chk("rr_data0", m0_bus.readdata, 32'h11AD33EF); end
        if (m1_bus.readdatavalid) begin n1++; chk("rr_data1", m1_bus.readdata, 0); end
      end
      tick(); settle();
    end
    m0_bus.read = 1'b0; m1_bus.read = 1'b0;
    settle();
    chk("rr_last_rdv", {m0_bus.readdatavalid, m1_bus.readdatavalid}, 2'b01);
    if (m1_bus.readdatavalid) n1++;
    chk("rr_count", {n0[7:0], n1[7:0]}, 16'h0404);

    // Lone m0 streams 4 reads with no bubbles
    for (int k = 0; k < 4; k++) begin
      tick();
      m0_bus.read = 1'b1; m0_bus.address = AW'(k);
      settle();
      chk("lone_wait", m0_bus.waitrequest, 0);
      chk("lone_addr", mem_address, 64'(k));
      if (k > 0) chk("lone_rdv", m0_bus.readdatavalid, 1);
    end
    tick(); m0_bus.read = 1'b0; settle();
    chk("lone_last_rdv", m0_bus.readdatavalid, 1);

    // reset_req after an accepted m1 read
    tick();
    m1_bus.read = 1'b1; m1_bus.address = 5'h10;
    settle();
    chk("rq_m1_accept", m1_bus.waitrequest, 0);
    tick();
    m1_bus.read = 1'b0; reset_req = 1'b1;
    m0_bus.read = 1'b1; m0_bus.address = 5'h11;
    settle();
    chk("rq_m1_rdv", m1_bus.readdatavalid, 1);
    chk("rq_m1_data", m1_bus.readdata, 32'h11AD33EF);
    chk("rq_stall1", {m0_bus.waitrequest, mem_chipselect}, 2'b10);
    tick(); settle();
    chk("rq_stall2", {m0_bus.waitrequest, m1_bus.readdatavalid}, 2'b10);
    tick(); settle();
    chk("rq_stall3", m0_bus.waitrequest, 1);
    tick(); reset_req = 1'b0; settle();
    chk("rq_release_accept", {m0_bus.waitrequest, mem_chipselect}, 2'b01);
    tick(); m0_bus.read = 1'b0; settle();
    chk("rq_m0_rdv", m0_bus.readdatavalid, 1);

    // Reset during an issued read: response discarded
    tick();
    m0_bus.read = 1'b1; m0_bus.address = 5'h10;
    settle();
    chk("ar_rd_accept", m0_bus.waitrequest, 0);
    #1 reset_n = 1'b0;
    idle_masters();
    tick(); settle();
    chk("ar_rdv_dropped", {m0_bus.readdatavalid, m1_bus.readdatavalid}, 2'b00);
    chk("ar_back_to_scrub", scrub_busy, 1);

    // Reset mid-scrub at counter 7: restart at address 0
    tick(); reset_n = 1'b1; settle();
    chk("ms_rdv_after", m0_bus.readdatavalid, 0);
    chk("ms_start", mem_address, 0);
    for (int i = 0; i < 7; i++) begin tick(); settle(); end
    chk("ms_cnt7", mem_address, 7);
    reset_n = 1'b0;
    settle();
    chk("ms_rst_cs", mem_chipselect, 0);
    tick(); reset_n = 1'b1; settle();
    chk("ms_restart", {scrub_busy, mem_chipselect, mem_address}, {2'b11, 5'd0});
    cyc = 0;
    while (scrub_busy && cyc < 40) begin tick(); settle(); cyc++; end
    chk("ms_scrub_len", cyc, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
